// File: rtl/servant_rr_arbiter.sv
// Two-master Wishbone classic arbiter with registered round-robin or fixed-priority grant.
// Define SERVANT_ARB_TIMEOUT_EN to enable the watchdog that terminates stalled slave cycles.
module servant_rr_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_m0_adr,
  input  logic [31:0] i_wb_m0_dat,
  input  logic [3:0]  i_wb_m0_sel,
  input  logic        i_wb_m0_we,
  input  logic        i_wb_m0_cyc,
  output logic [31:0] o_wb_m0_rdt,
  output logic        o_wb_m0_ack,
  input  logic [31:0] i_wb_m1_adr,
  input  logic [31:0] i_wb_m1_dat,
  input  logic [3:0]  i_wb_m1_sel,
  input  logic        i_wb_m1_we,
  input  logic        i_wb_m1_cyc,
  output logic [31:0] o_wb_m1_rdt,
  output logic        o_wb_m1_ack,
  output logic [31:0] o_wb_s_adr,
  output logic [31:0] o_wb_s_dat,
  output logic [3:0]  o_wb_s_sel,
  output logic        o_wb_s_we,
  output logic        o_wb_s_cyc,
  input  logic [31:0] i_wb_s_rdt,
  input  logic        i_wb_s_ack,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;
  logic        in_gnt_s;
  logic        own_cyc_s;
  logic        ack_s;
  logic        expire_s;
  logic        pick_m1_s;

  assign in_gnt_s  = (state_q == GNT);
  assign own_cyc_s = grant_q[1] ? i_wb_m1_cyc : (grant_q[0] & i_wb_m0_cyc);
  assign ack_s     = in_gnt_s & own_cyc_s & i_wb_s_ack;
  assign pick_m1_s = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;

`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd_q, wd_d;

  // Watchdog counts owned cycles; it is zero on every entry into GNT.
  always_comb begin
    wd_d = 16'd0;
    if (in_gnt_s) begin
      wd_d = wd_q + 16'd1;
    end else begin
      wd_d = 16'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q <= 16'd0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // A slave ack in the same cycle wins over expiry.
  assign expire_s = in_gnt_s & own_cyc_s & ~i_wb_s_ack & (wd_q == WD_LAST);
`else
  logic [15:0] unused_timeout_s;
  assign unused_timeout_s = 16'(TIMEOUT);
  assign expire_s = 1'b0;
`endif

  // Outside GNT the slave sees m0's request fields so nothing floats to X.
  assign o_wb_s_adr  = grant_q[1] ? i_wb_m1_adr : i_wb_m0_adr;
  assign o_wb_s_dat  = grant_q[1] ? i_wb_m1_dat : i_wb_m0_dat;
  assign o_wb_s_sel  = grant_q[1] ? i_wb_m1_sel : i_wb_m0_sel;
  assign o_wb_s_we   = grant_q[1] ? i_wb_m1_we  : i_wb_m0_we;
  assign o_wb_s_cyc  = in_gnt_s & own_cyc_s & ~expire_s;
  assign o_wb_m0_ack = grant_q[0] & (ack_s | expire_s);
  assign o_wb_m1_ack = grant_q[1] & (ack_s | expire_s);
  assign o_wb_m0_rdt = expire_s ? 32'h0 : i_wb_s_rdt;
  assign o_wb_m1_rdt = expire_s ? 32'h0 : i_wb_s_rdt;
  assign o_grant     = grant_q;
  assign o_timeout   = expire_s;

  // Arbitration and transfer-tracking next state.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_wb_m0_cyc && i_wb_m1_cyc) begin
          grant_d = pick_m1_s ? 2'b10 : 2'b01;
          state_d = GNT;
        end else if (i_wb_m0_cyc) begin
          grant_d = 2'b01;
          state_d = GNT;
        end else if (i_wb_m1_cyc) begin
          grant_d = 2'b10;
          state_d = GNT;
        end else begin
          grant_d = 2'b00;
        end
      end
      GNT: begin
        if (ack_s || expire_s) begin
          last_d  = grant_q[1];
          grant_d = 2'b00;
          state_d = HOLD;
        end else if (!own_cyc_s) begin
          grant_d = 2'b00;
          state_d = HOLD;
        end else begin
          grant_d = grant_q;
        end
      end
      HOLD: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  // Pointer resets to m1 so that m0 wins the first contention.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule
